// File: rtl/add_arbiter_pkg.sv
// add_arbiter_pkg: FSM state encodings and the clog2 helper shared by the arbiter files
package add_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cl_adder.sv
// cl_adder: generate/propagate adder producing a SIZE-bit sum and carry-out
module cl_adder #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] sum,
  output logic            c_out
);
  logic [SIZE-1:0] g;
  logic [SIZE-1:0] p;
  logic            carry;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < SIZE; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    c_out = carry;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  logic [IDW-1:0] j;
  always_comb begin
    j       = '0;
    gnt_idx = '0;
    // Walk offsets from farthest to nearest so the nearest match overwrites the rest.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) gnt_idx = j;
    end
    gnt = |req ? NREQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one cl_adder among NREQ requesters; ADD_ARBITER_OVF_EN adds rsp_ovf
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int  SIZE = 32,
  parameter int  NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [SIZE-1:0]      rsp_sum,
`ifdef ADD_ARBITER_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic                 rsp_cout
);
  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, gnt_idx, op_id;
  logic [NREQ-1:0] gnt;
  logic [SIZE-1:0] op_a, op_b, sel_a, sel_b, sum;
  logic            c_out, take;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  cl_adder #(.SIZE(SIZE)) u_add (
    .a     (op_a),
    .b     (op_b),
    .sum   (sum),
    .c_out (c_out)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        sel_a = req_a[i*SIZE +: SIZE];
        sel_b = req_b[i*SIZE +: SIZE];
      end
  end

  assign take      = state == ST_IDLE && |req_valid;
  assign req_ready = (state == ST_IDLE && !rst) ? gnt : '0;
  assign rsp_valid = state == ST_RESP;

  always_comb begin
    state_nx = state == ST_IDLE ? (take ? ST_CALC : ST_IDLE) :
               state == ST_CALC ? ST_RESP :
               (state == ST_RESP && !rsp_ready) ? ST_RESP : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef ADD_ARBITER_OVF_EN
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (take) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == ST_CALC) begin
        rsp_sum  <= sum;
        rsp_cout <= c_out;
        rsp_id   <= op_id;
`ifdef ADD_ARBITER_OVF_EN
        rsp_ovf  <= op_a[SIZE-1] == op_b[SIZE-1] && sum[SIZE-1] != op_a[SIZE-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter (SIZE=32, NREQ=4)
module tb_add_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;
`ifdef ADD_ARBITER_OVF_EN
  logic         rsp_ovf;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_arbiter #(.SIZE(32), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADD_ARBITER_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_cout  (rsp_cout)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", rsp_cout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin;
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_sum[5] = '{1, 2, 3, 4, 1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd1);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (req_ready !== 4'(1 << exp_id[k])) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_id[k])); end
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_calc_valid[%0d]: got %b want 0", k, rsp_valid); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", k, rsp_valid); end
      checks++; if (rsp_id !== 2'(exp_id[k])) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, exp_id[k]); end
      checks++; if (rsp_sum !== 32'(exp_sum[k])) begin errors++; $display("FAIL rr_sum[%0d]: got %0d want %0d", k, rsp_sum, exp_sum[k]); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    rsp_ready = 1'b1;
    set_req(0, 32'd6, 32'd5);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_calc_ready: got %b want 0000", req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_sum !== 32'd11) begin errors++; $display("FAIL single_sum: got %0d want 11", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL single_cout: got %b want 0", rsp_cout); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_carry;
    rsp_ready = 1'b1;
    set_req(2, 32'hFFFF_FFFF, 32'd1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL carry_sum: got %h want 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b want 1", rsp_cout); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL carry_id: got %0d want 2", rsp_id); end
    step();
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    set_req(3, 32'd10, 32'd20);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_ready: got %b want 1000", req_ready); end
    step();
    req_valid = '0;
    set_req(0, 32'd1, 32'd2);
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
      checks++; if (rsp_sum !== 32'd30) begin errors++; $display("FAIL bp_sum[%0d]: got %0d want 30", c, rsp_sum); end
      checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL bp_id[%0d]: got %0d want 3", c, rsp_id); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0000", c, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_reaccept: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_sum !== 32'd3) begin errors++; $display("FAIL bp_next_sum: got %0d want 3", rsp_sum); end
    step();
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b1;
    set_req(1, 32'd3, 32'd7);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_ready: got %b want 0010", req_ready); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rmid_req_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL rmid_sum: got %h want 0", rsp_sum); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_id: got %0d want 0", rsp_id); end
    req_valid = '0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got %b want 0", c, rsp_valid); end
    end
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_next_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'd1) begin errors++; $display("FAIL rmid_next_sum: got %0d want 1", rsp_sum); end
    step();
  endtask

`ifdef ADD_ARBITER_OVF_EN
  task automatic test_ovf;
    rsp_ready = 1'b1;
    set_req(1, 32'h7FFF_FFFF, 32'd1);
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", rsp_ovf); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL ovf_cout: got %b want 0", rsp_cout); end
    checks++; if (rsp_sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum: got %h want 80000000", rsp_sum); end
    step();
    set_req(1, 32'd8, 32'd9);
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", rsp_ovf); end
    checks++; if (rsp_sum !== 32'd17) begin errors++; $display("FAIL ovf_sum17: got %0d want 17", rsp_sum); end
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_carry();
    test_backpressure();
    test_reset_mid();
`ifdef ADD_ARBITER_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
